// File: rtl/trng_conditioner.sv
// Ring-oscillator TRNG conditioner: per-channel 2-flop sync, XOR combine, prescaled sampling,
// optional von Neumann debias, repetition-count health test and word packing onto valid/ready.

module trng_sync_lane (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

module trng_conditioner #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int DIV       = 16,
  parameter int REP_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vn_en,
  input  logic [NUM_CH-1:0] rnd_in,
  input  logic              fault_clr,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fault
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int BW = $clog2(WIDTH + 1);

  logic [NUM_CH-1:0] sync_q;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     rep, rep_nxt;
  logic              prev_raw, raw, tick, trip;
  logic              phase, first;
  logic              take, pair_ok, bit_in, accept;
  logic [WIDTH-1:0]  sreg, word_nxt;
  logic [BW-1:0]     bcnt;
  logic              full, last, slot_free, xfer;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      trng_sync_lane u_lane (.clk(clk), .rst(rst), .d(rnd_in[i]), .q(sync_q[i]));
    end
  endgenerate

  assign raw  = ^sync_q;
  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (en)  cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
  end

  // rep == 0 marks "no previous sample" (after reset or a fault clear)
  always_comb begin
    rep_nxt = RW'(1);
    if (rep != '0 && raw == prev_raw)
      rep_nxt = (rep == RW'(REP_LIMIT)) ? rep : rep + RW'(1);
  end

  assign trip = tick && (rep_nxt == RW'(REP_LIMIT)) && (rep != RW'(REP_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      fault    <= 1'b0;
      rep      <= '0;
      prev_raw <= 1'b0;
    end else if (trip) begin
      fault    <= 1'b1;
      rep      <= rep_nxt;
      prev_raw <= raw;
    end else if (fault_clr) begin
      fault    <= 1'b0;
      rep      <= '0;
    end else if (tick) begin
      rep      <= rep_nxt;
      prev_raw <= raw;
    end
  end

  assign take      = tick && !fault && !trip;
  assign pair_ok   = vn_en ? (phase && (first != raw)) : 1'b1;
  assign bit_in    = vn_en ? first : raw;
  assign full      = (bcnt == BW'(WIDTH));
  assign accept    = take && pair_ok && !full;
  assign last      = accept && (bcnt == BW'(WIDTH - 1));
  assign xfer      = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign word_nxt  = {sreg[WIDTH-2:0], bit_in};

  // Leaving VN mode holds the phase at "first", so any vn_en change restarts the pair
  always_ff @(posedge clk) begin
    if (rst || trip || !vn_en) begin
      phase <= 1'b0;
      first <= 1'b0;
    end else if (take) begin
      phase <= ~phase;
      if (!phase) first <= raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      bcnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (trip) begin
      sreg      <= '0;
      bcnt      <= '0;
      out_valid <= 1'b0;
    end else if (full && slot_free) begin
      out_data  <= sreg;
      out_valid <= 1'b1;
      bcnt      <= '0;
    end else if (last && slot_free) begin
      // final bit goes straight to the output so out_valid rises right after its tick
      sreg      <= word_nxt;
      out_data  <= word_nxt;
      out_valid <= 1'b1;
      bcnt      <= '0;
    end else begin
      if (xfer) out_valid <= 1'b0;
      if (accept) begin
        sreg <= word_nxt;
        bcnt <= bcnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: table-driven word vectors plus hand sequences for
// health fault, backpressure, prescaler/enable and mid-word reset.

module tb_trng_conditioner;
  logic       clk = 1'b0;
  logic       rst, en, vn_en, fault_clr, out_ready;
  logic [3:0] rnd_in;
  logic [7:0] out_data;
  logic       out_valid, fault;

  logic       rst4, en4;
  logic [3:0] rnd4;
  logic [7:0] out_data4;
  logic       out_valid4, fault4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  trng_conditioner #(.NUM_CH(4), .WIDTH(8), .DIV(1), .REP_LIMIT(32)) u_dut (
    .clk(clk), .rst(rst), .en(en), .vn_en(vn_en), .rnd_in(rnd_in), .fault_clr(fault_clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fault(fault)
  );

  trng_conditioner #(.NUM_CH(4), .WIDTH(8), .DIV(4), .REP_LIMIT(32)) u_div4 (
    .clk(clk), .rst(rst4), .en(en4), .vn_en(1'b0), .rnd_in(rnd4), .fault_clr(1'b0),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(1'b0), .fault(fault4)
  );

  typedef struct {
    logic [23:0] s;
    int          n;
    logic        vn;
    logic        exp_pre;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; fault_clr = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Upper channels random, bit 0 chosen so the XOR of all four equals b
  function automatic logic [3:0] enc(input logic b);
    logic [2:0] up;
    up = 3'($urandom_range(0, 7));
    return {up, b ^ (^up)};
  endfunction

  // Bit i lands on raw two edges after it is driven; en is held low while the sync fills
  task automatic feed(input logic [23:0] s, input int n, output logic pre);
    pre = 1'b0;
    for (int j = 0; j < n + 2; j++) begin
      if (j < n) rnd_in = enc(s[n-1-j]);
      en = (j >= 2);
      step();
      if (j == n) pre = out_valid;
    end
    en = 1'b0;
  endtask

  initial begin
    logic pre;
    tbl[0] = '{24'h0000B2,  8, 1'b0, 1'b0, 8'hB2};
    tbl[1] = '{24'h00005A,  8, 1'b0, 1'b0, 8'h5A};
    tbl[2] = '{24'h00000F,  8, 1'b0, 1'b0, 8'h0F};
    tbl[3] = '{24'h00AAAA, 16, 1'b1, 1'b0, 8'hFF};
    tbl[4] = '{24'h639699, 24, 1'b1, 1'b1, 8'h66};

    rst = 1'b1; en = 1'b1; vn_en = 1'b0; fault_clr = 1'b0; out_ready = 1'b1; rnd_in = 4'hF;
    rst4 = 1'b1; en4 = 1'b0; rnd4 = 4'h0;
    step(); step();
    chk("rst_data",  {24'h0, out_data}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    rst = 1'b0; en = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      vn_en = tbl[i].vn;
      feed(tbl[i].s, tbl[i].n, pre);
      chk($sformatf("vec%0d_pre_valid", i), {31'h0, pre}, {31'h0, tbl[i].exp_pre});
      chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("vec%0d_data", i), {24'h0, out_data}, {24'h0, tbl[i].exp});
      chk($sformatf("vec%0d_fault", i), {31'h0, fault}, 32'h0);
    end
    vn_en = 1'b0;

    // Health: constant raw trips on the 32nd tick
    do_reset();
    rnd_in = 4'h0; en = 1'b1;
    repeat (31) step();
    chk("rep31_fault", {31'h0, fault}, 32'h0);
    chk("rep31_valid", {31'h0, out_valid}, 32'h1);
    step();
    chk("rep32_fault", {31'h0, fault}, 32'h1);
    chk("rep32_valid", {31'h0, out_valid}, 32'h0);
    repeat (3) step();
    chk("fault_sticky", {31'h0, fault}, 32'h1);
    chk("fault_novalid", {31'h0, out_valid}, 32'h0);
    en = 1'b0; fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("fault_clr", {31'h0, fault}, 32'h0);
    feed(24'h0000B2, 8, pre);
    chk("resume_valid", {31'h0, out_valid}, 32'h1);
    chk("resume_data", {24'h0, out_data}, 32'hB2);

    // Backpressure: two words, first held, second waits in sreg
    do_reset();
    feed(24'h00C35A, 16, pre);
    chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_hold_data", {24'h0, out_data}, 32'hC3);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_second_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_second_data", {24'h0, out_data}, 32'h5A);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_drain_valid", {31'h0, out_valid}, 32'h0);

    // Reset mid-word discards partial bits
    do_reset();
    feed(24'h0000B2, 8, pre);
    feed(24'h00001F, 5, pre);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_data", {24'h0, out_data}, 32'h0);
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    feed(24'h000096, 8, pre);
    chk("mid_rst_pre", {31'h0, pre}, 32'h0);
    chk("mid_rst_word", {24'h0, out_data}, 32'h96);

    // DIV=4: ticks on edges 4,8,..; 8th tick at edge 32
    rnd4 = 4'b0001; rst4 = 1'b1; step();
    chk("d4_rst_valid", {31'h0, out_valid4}, 32'h0);
    rst4 = 1'b0; en4 = 1'b1;
    repeat (31) step();
    chk("d4_edge31_valid", {31'h0, out_valid4}, 32'h0);
    step();
    chk("d4_edge32_valid", {31'h0, out_valid4}, 32'h1);
    chk("d4_edge32_data", {24'h0, out_data4}, 32'hFF);
    chk("d4_fault", {31'h0, fault4}, 32'h0);

    // en=0 freezes the prescaler mid-count (3 ticks done, cnt=2)
    rst4 = 1'b1; step(); rst4 = 1'b0; en4 = 1'b1;
    repeat (14) step();
    en4 = 1'b0;
    repeat (10) step();
    chk("d4_freeze_valid", {31'h0, out_valid4}, 32'h0);
    en4 = 1'b1;
    repeat (17) step();
    chk("d4_resume17_valid", {31'h0, out_valid4}, 32'h0);
    step();
    chk("d4_resume18_valid", {31'h0, out_valid4}, 32'h1);
    en4 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
